parking_ctrl_param: RTL and testbench

Parametrised, fully synchronous successor of the parking control unit. It tracks occupancy for two vehicle classes (university and general) in a shared lot, enforces per-class quotas, and applies a time-of-day schedule to the general quota. It also accepts or rejects every entry and exit request with a registered one-cycle handshake. It sits between the gate sensors and the display/barrier logic.

---
 rtl/parking_ctrl_param.sv | 147 ++++++++++++++
 tb/tb_parking_ctrl_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_ctrl_param.sv
// Parking lot occupancy controller: two vehicle classes, per-class quotas, an
// hour-scheduled general quota and a registered one-cycle ack/nack per request.
module parking_ctrl_param #(
  parameter int TOTAL_SPACE     = 700,
  parameter int UNI_QUOTA       = 500,
  parameter int GEN_QUOTA_BASE  = 200,
  parameter int GEN_QUOTA_STEP1 = 250,
  parameter int GEN_QUOTA_STEP2 = 350,
  parameter int HOUR_STEP1      = 13,
  parameter int HOUR_STEP2      = 16,
  parameter int START_HOUR      = 8,
  parameter int CYCLES_PER_HOUR = 3600,
  parameter int CNT_W           = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             entry_is_uni,
  input  logic             exit_req,
  input  logic             exit_is_uni,
  output logic             entry_ack,
  output logic             entry_nack,
  output logic             exit_ack,
  output logic             exit_nack,
  output logic [CNT_W-1:0] uni_parked_car,
  output logic [CNT_W-1:0] parked_car,
  output logic [CNT_W-1:0] uni_vacated_space,
  output logic [CNT_W-1:0] vacated_space,
  output logic             uni_is_vacated_space,
  output logic             is_vacated_space,
  output logic [4:0]       hour
);

  localparam int SW    = CNT_W + 1;
  localparam int SEC_W = (CYCLES_PER_HOUR > 1) ? $clog2(CYCLES_PER_HOUR) : 1;

  localparam logic [SEC_W-1:0]       SEC_LAST  = SEC_W'(CYCLES_PER_HOUR - 1);
  localparam logic [SEC_W-1:0]       SEC_ONE   = SEC_W'(1);
  localparam logic [4:0]             HOUR_INIT = 5'(START_HOUR);
  localparam logic [4:0]             HOUR_S1   = 5'(HOUR_STEP1);
  localparam logic [4:0]             HOUR_S2   = 5'(HOUR_STEP2);
  localparam logic [4:0]             HOUR_LAST = 5'd23;
  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
  localparam logic signed [SW-1:0]   TOTAL_S   = SW'(TOTAL_SPACE);
  localparam logic signed [SW-1:0]   UNI_Q_S   = SW'(UNI_QUOTA);
  localparam logic signed [SW-1:0]   GEN_Q0_S  = SW'(GEN_QUOTA_BASE);
  localparam logic signed [SW-1:0]   GEN_Q1_S  = SW'(GEN_QUOTA_STEP1);
  localparam logic signed [SW-1:0]   GEN_Q2_S  = SW'(GEN_QUOTA_STEP2);

  // min(a, b) clamped at zero; a negative room (quota lowered below count) gives 0
  function automatic logic [CNT_W-1:0] sat_min0(input logic signed [SW-1:0] a,
                                                input logic signed [SW-1:0] b);
    logic signed [SW-1:0] m;
    m = (a < b) ? a : b;
    return m[SW-1] ? '0 : m[CNT_W-1:0];
  endfunction

  logic [SEC_W-1:0]     sec_q, sec_d;
  logic [4:0]           hour_q, hour_d;
  logic [CNT_W-1:0]     uni_cnt_q, uni_cnt_d;
  logic [CNT_W-1:0]     gen_cnt_q, gen_cnt_d;
  logic                 entry_ack_q, entry_ack_d, entry_nack_q, entry_nack_d;
  logic                 exit_ack_q, exit_ack_d, exit_nack_q, exit_nack_d;

  logic signed [SW-1:0] gen_quota;
  logic signed [SW-1:0] free_s, uni_room_s, gen_room_s;
  logic [CNT_W-1:0]     uni_vac, gen_vac;
  logic                 entry_acc, exit_acc;
  logic                 uni_in, uni_out, gen_in, gen_out;

  always_comb begin
    gen_quota = GEN_Q0_S;
    if (hour_q >= HOUR_S2)      gen_quota = GEN_Q2_S;
    else if (hour_q >= HOUR_S1) gen_quota = GEN_Q1_S;
  end

  assign free_s     = TOTAL_S - $signed({1'b0, uni_cnt_q}) - $signed({1'b0, gen_cnt_q});
  assign uni_room_s = UNI_Q_S - $signed({1'b0, uni_cnt_q});
  assign gen_room_s = gen_quota - $signed({1'b0, gen_cnt_q});
  assign uni_vac    = sat_min0(uni_room_s, free_s);
  assign gen_vac    = sat_min0(gen_room_s, free_s);

  // Entry and exit are judged independently on pre-edge state
  assign entry_acc = entry_req & (entry_is_uni ? (uni_vac != '0) : (gen_vac != '0));
  assign exit_acc  = exit_req & (exit_is_uni ? (uni_cnt_q != '0) : (gen_cnt_q != '0));
  assign uni_in    = entry_acc & entry_is_uni;
  assign gen_in    = entry_acc & ~entry_is_uni;
  assign uni_out   = exit_acc & exit_is_uni;
  assign gen_out   = exit_acc & ~exit_is_uni;

  always_comb begin
    sec_d        = sec_q + SEC_ONE;
    hour_d       = hour_q;
    uni_cnt_d    = uni_cnt_q;
    gen_cnt_d    = gen_cnt_q;
    entry_ack_d  = entry_acc;
    entry_nack_d = entry_req & ~entry_acc;
    exit_ack_d   = exit_acc;
    exit_nack_d  = exit_req & ~exit_acc;

    if (sec_q == SEC_LAST) begin
      sec_d  = '0;
      hour_d = (hour_q == HOUR_LAST) ? 5'd0 : hour_q + 5'd1;
    end

    if (uni_in && !uni_out)      uni_cnt_d = uni_cnt_q + CNT_ONE;
    else if (!uni_in && uni_out) uni_cnt_d = uni_cnt_q - CNT_ONE;

    if (gen_in && !gen_out)      gen_cnt_d = gen_cnt_q + CNT_ONE;
    else if (!gen_in && gen_out) gen_cnt_d = gen_cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q        <= '0;
      hour_q       <= HOUR_INIT;
      uni_cnt_q    <= '0;
      gen_cnt_q    <= '0;
      entry_ack_q  <= 1'b0;
      entry_nack_q <= 1'b0;
      exit_ack_q   <= 1'b0;
      exit_nack_q  <= 1'b0;
    end else begin
      sec_q        <= sec_d;
      hour_q       <= hour_d;
      uni_cnt_q    <= uni_cnt_d;
      gen_cnt_q    <= gen_cnt_d;
      entry_ack_q  <= entry_ack_d;
      entry_nack_q <= entry_nack_d;
      exit_ack_q   <= exit_ack_d;
      exit_nack_q  <= exit_nack_d;
    end
  end

  assign entry_ack            = entry_ack_q;
  assign entry_nack           = entry_nack_q;
  assign exit_ack             = exit_ack_q;
  assign exit_nack            = exit_nack_q;
  assign uni_parked_car       = uni_cnt_q;
  assign parked_car           = gen_cnt_q;
  assign uni_vacated_space    = uni_vac;
  assign vacated_space        = gen_vac;
  assign uni_is_vacated_space = (uni_vac != '0);
  assign is_vacated_space     = (gen_vac != '0);
  assign hour                 = hour_q;

endmodule

// File: tb/tb_parking_ctrl_param.sv
// Bench for parking_ctrl_param: a default instance (3600 cycles/hour) and a
// fast-clock instance (4 cycles/hour), both tracked by an arithmetic model.
module tb_parking_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2], en_req[2], en_uni[2], ex_req[2], ex_uni[2];
  logic       eack[2], enack[2], xack[2], xnack[2], uisv[2], isv[2];
  logic [9:0] upc[2], gpc[2], uvs[2], gvs[2];
  logic [4:0] hr[2];

  parking_ctrl_param u_dut0 (
    .clk(clk), .reset(rst[0]),
    .entry_req(en_req[0]), .entry_is_uni(en_uni[0]),
    .exit_req(ex_req[0]), .exit_is_uni(ex_uni[0]),
    .entry_ack(eack[0]), .entry_nack(enack[0]),
    .exit_ack(xack[0]), .exit_nack(xnack[0]),
    .uni_parked_car(upc[0]), .parked_car(gpc[0]),
    .uni_vacated_space(uvs[0]), .vacated_space(gvs[0]),
    .uni_is_vacated_space(uisv[0]), .is_vacated_space(isv[0]),
    .hour(hr[0])
  );

  parking_ctrl_param #(.CYCLES_PER_HOUR(4)) u_dut1 (
    .clk(clk), .reset(rst[1]),
    .entry_req(en_req[1]), .entry_is_uni(en_uni[1]),
    .exit_req(ex_req[1]), .exit_is_uni(ex_uni[1]),
    .entry_ack(eack[1]), .entry_nack(enack[1]),
    .exit_ack(xack[1]), .exit_nack(xnack[1]),
    .uni_parked_car(upc[1]), .parked_car(gpc[1]),
    .uni_vacated_space(uvs[1]), .vacated_space(gvs[1]),
    .uni_is_vacated_space(uisv[1]), .is_vacated_space(isv[1]),
    .hour(hr[1])
  );

  int total = 0;
  int bad   = 0;

  // Reference model state per instance
  int cph[2] = '{3600, 4};
  int m_uni[2], m_gen[2], m_hour[2], m_sec[2];
  int m_ea[2], m_en[2], m_xa[2], m_xn[2];

  function automatic int gen_quota(input int h);
    if (h >= 16) return 350;
    if (h >= 13) return 250;
    return 200;
  endfunction

  function automatic int clamp_min(input int a, input int b);
    int v;
    v = (a < b) ? a : b;
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int exp_uvac(input int i);
    return clamp_min(500 - m_uni[i], 700 - m_uni[i] - m_gen[i]);
  endfunction

  function automatic int exp_gvac(input int i);
    return clamp_min(gen_quota(m_hour[i]) - m_gen[i], 700 - m_uni[i] - m_gen[i]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input int i);
    bit ea, xa;
    if (rst[i]) begin
      m_uni[i] = 0; m_gen[i] = 0; m_sec[i] = 0; m_hour[i] = 8;
      m_ea[i] = 0; m_en[i] = 0; m_xa[i] = 0; m_xn[i] = 0;
    end else begin
      ea = en_req[i] && (en_uni[i] ? (exp_uvac(i) > 0) : (exp_gvac(i) > 0));
      xa = ex_req[i] && (ex_uni[i] ? (m_uni[i] > 0) : (m_gen[i] > 0));
      m_ea[i] = ea; m_en[i] = en_req[i] && !ea;
      m_xa[i] = xa; m_xn[i] = ex_req[i] && !xa;
      if (ea) begin
        if (en_uni[i]) m_uni[i]++; else m_gen[i]++;
      end
      if (xa) begin
        if (ex_uni[i]) m_uni[i]--; else m_gen[i]--;
      end
      if (m_sec[i] == cph[i] - 1) begin
        m_sec[i]  = 0;
        m_hour[i] = (m_hour[i] + 1) % 24;
      end else begin
        m_sec[i]++;
      end
    end
  endtask

  task automatic check_model(input int i);
    chk($sformatf("m%0d_entry_ack", i),  eack[i],  m_ea[i]);
    chk($sformatf("m%0d_entry_nack", i), enack[i], m_en[i]);
    chk($sformatf("m%0d_exit_ack", i),   xack[i],  m_xa[i]);
    chk($sformatf("m%0d_exit_nack", i),  xnack[i], m_xn[i]);
    chk($sformatf("m%0d_uni_parked", i), upc[i],   m_uni[i]);
    chk($sformatf("m%0d_parked", i),     gpc[i],   m_gen[i]);
    chk($sformatf("m%0d_uni_vac", i),    uvs[i],   exp_uvac(i));
    chk($sformatf("m%0d_vac", i),        gvs[i],   exp_gvac(i));
    chk($sformatf("m%0d_uni_isvac", i),  uisv[i],  exp_uvac(i) > 0);
    chk($sformatf("m%0d_isvac", i),      isv[i],   exp_gvac(i) > 0);
    chk($sformatf("m%0d_hour", i),       hr[i],    m_hour[i]);
  endtask

  task automatic step();
    model_update(0);
    model_update(1);
    @(posedge clk);
    #1;
    check_model(0);
    check_model(1);
  endtask

  task automatic idle(input int i);
    en_req[i] = 1'b0; ex_req[i] = 1'b0; en_uni[i] = 1'b0; ex_uni[i] = 1'b0;
  endtask

  typedef struct {
    logic rst, er, eu, xr, xu;
    logic ea, en, xa, xn;
    int   uni, gen, uvac, gvac;
  } vec_t;

  vec_t tbl[10];

  initial begin
    //            rst er eu xr xu  ea en xa xn  uni gen uvac gvac
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 500, 200};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 499, 200};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 498, 200};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 497, 200};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0, 497, 200};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1, 497, 199};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3, 1, 497, 199};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, 2, 498, 198};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1, 498, 199};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 500, 200};

    idle(0); idle(1);
    rst[0] = 1'b1; rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;

    // Table vectors on the default instance
    for (int v = 0; v < 10; v++) begin
      rst[0] = tbl[v].rst; en_req[0] = tbl[v].er; en_uni[0] = tbl[v].eu;
      ex_req[0] = tbl[v].xr; ex_uni[0] = tbl[v].xu;
      step();
      chk($sformatf("tbl%0d_entry_ack", v),  eack[0],  tbl[v].ea);
      chk($sformatf("tbl%0d_entry_nack", v), enack[0], tbl[v].en);
      chk($sformatf("tbl%0d_exit_ack", v),   xack[0],  tbl[v].xa);
      chk($sformatf("tbl%0d_exit_nack", v),  xnack[0], tbl[v].xn);
      chk($sformatf("tbl%0d_uni_parked", v), upc[0],   tbl[v].uni);
      chk($sformatf("tbl%0d_parked", v),     gpc[0],   tbl[v].gen);
      chk($sformatf("tbl%0d_uni_vac", v),    uvs[0],   tbl[v].uvac);
      chk($sformatf("tbl%0d_vac", v),        gvs[0],   tbl[v].gvac);
    end
    rst[0] = 1'b0;
    idle(0);

    // General class to its hour-8 quota, then one more
    en_req[0] = 1'b1; en_uni[0] = 1'b0;
    for (int k = 0; k < 200; k++) step();
    chk("gen_fill_parked", gpc[0], 200);
    step();
    chk("gen_201_nack", enack[0], 1);
    chk("gen_201_ack", eack[0], 0);
    chk("gen_201_parked", gpc[0], 200);
    chk("gen_full_vac", gvs[0], 0);
    chk("gen_full_isvac", isv[0], 0);
    chk("gen_full_hour", hr[0], 8);

    // Full general class: same-cycle entry and exit
    ex_req[0] = 1'b1; ex_uni[0] = 1'b0;
    step();
    chk("simul_entry_nack", enack[0], 1);
    chk("simul_exit_ack", xack[0], 1);
    chk("simul_parked", gpc[0], 199);
    idle(0);

    // Schedule on the fast instance
    rst[1] = 1'b1; step(); rst[1] = 1'b0;
    en_req[1] = 1'b1; en_uni[1] = 1'b0;
    for (int k = 0; k < 1000 && m_gen[1] < 200; k++) step();
    idle(1);
    chk("sched_fill200", gpc[1], 200);
    for (int k = 0; k < 200 && m_hour[1] != 13; k++) step();
    chk("sched_hour13", hr[1], 13);
    chk("sched_vac13", gvs[1], 50);
    for (int k = 0; k < 200 && m_hour[1] != 16; k++) step();
    chk("sched_hour16", hr[1], 16);
    chk("sched_vac16", gvs[1], 150);
    en_req[1] = 1'b1; en_uni[1] = 1'b0;
    for (int k = 0; k < 3000 && m_gen[1] < 350; k++) step();
    idle(1);
    chk("sched_fill350", gpc[1], 350);
    for (int k = 0; k < 200 && m_hour[1] != 0; k++) step();
    chk("wrap_hour0", hr[1], 0);
    chk("wrap_vac0", gvs[1], 0);
    chk("wrap_isvac0", isv[1], 0);
    chk("wrap_parked", gpc[1], 350);

    // Lot completely full at hour 16
    rst[1] = 1'b1; step(); rst[1] = 1'b0;
    en_req[1] = 1'b1; en_uni[1] = 1'b1;
    for (int k = 0; k < 1000 && m_uni[1] < 500; k++) step();
    en_uni[1] = 1'b0;
    for (int k = 0; k < 2000 && m_gen[1] < 200; k++) step();
    idle(1);
    chk("full_uni500", upc[1], 500);
    chk("full_gen200", gpc[1], 200);
    for (int k = 0; k < 200 && m_hour[1] != 16; k++) step();
    chk("full_hour16", hr[1], 16);
    chk("full_uvac", uvs[1], 0);
    chk("full_gvac", gvs[1], 0);
    chk("full_uisvac", uisv[1], 0);
    chk("full_isvac", isv[1], 0);
    en_req[1] = 1'b1; en_uni[1] = 1'b1;
    step();
    chk("full_uni_nack", enack[1], 1);
    chk("full_uni_cnt", upc[1], 500);
    en_uni[1] = 1'b0;
    step();
    chk("full_gen_nack", enack[1], 1);
    chk("full_gen_cnt", gpc[1], 200);
    rst[1] = 1'b1;
    step();
    chk("rst_entry_ack", eack[1], 0);
    chk("rst_entry_nack", enack[1], 0);
    chk("rst_uni", upc[1], 0);
    chk("rst_gen", gpc[1], 0);
    chk("rst_hour", hr[1], 8);
    rst[1] = 1'b0;
    idle(1);

    // Randomized traffic on both instances
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        en_req[i] = ($urandom_range(0, 9) < 7);
        en_uni[i] = 1'($urandom_range(0, 1));
        ex_req[i] = ($urandom_range(0, 9) < 3);
        ex_uni[i] = 1'($urandom_range(0, 1));
        rst[i]    = ($urandom_range(0, 299) == 0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
